// File: rtl/mem_io_bridge.sv
// Memory-side bridge: passes CPU accesses through to memory, except for a
// 4-word I/O window that holds a TX FIFO, an RX FIFO and a status register.

// Small synchronous FIFO; callers only push when not full and pop when not empty.
module mem_io_bridge_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] store [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = store[rd_ptr];
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
endmodule

module mem_io_bridge #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int IO_BASE    = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic [DATA_WIDTH-1:0] cpu_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(IO_BASE);

  logic                  hit;
  logic [1:0]            off;
  logic [3:0]            acc_cur;
  logic [3:0]            acc_prev;
  logic                  start;
  logic                  tx_wr, rx_rd, st_wr;
  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  ovf, udf, ovf_set, udf_set;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  sel;
  logic [DATA_WIDTH-1:0] io_rdata;

  // Window is 4-aligned, so the decode is an upper-bits compare.
  assign hit     = (cpu_addr[ADDR_WIDTH-1:2] == BASE[ADDR_WIDTH-1:2]);
  assign off     = cpu_addr[1:0];
  assign acc_cur = {hit, off, cpu_we};
  // A new access begins only when the (hit, offset, we) tuple changes, so a
  // held access has exactly one side effect.
  assign start   = hit && (acc_cur != acc_prev);

  assign mem_we   = cpu_we & ~hit;
  assign mem_addr = cpu_addr;
  assign mem_data = cpu_data;

  assign tx_wr   = start &  cpu_we & (off == 2'd0);
  assign rx_rd   = start & ~cpu_we & (off == 2'd1);
  assign st_wr   = start &  cpu_we & (off == 2'd2);

  // Full is judged on pre-edge state: a same-cycle sink pop does not save the word.
  assign tx_push = tx_wr & ~tx_full;
  assign ovf_set = tx_wr &  tx_full;
  assign tx_pop  = tx_valid & tx_ready;
  assign tx_valid = ~tx_empty;

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rx_rd & ~rx_empty;
  assign udf_set  = rx_rd &  rx_empty;

  assign status = {{(DATA_WIDTH-6){1'b0}}, udf, ovf, tx_full, tx_empty, rx_full, rx_empty};

  // Value latched into io_rdata when an access starts.
  always_comb begin
    rd_val = '0;
    if (!cpu_we) begin
      case (off)
        2'd1:    rd_val = rx_empty ? '0 : rx_head;
        2'd2:    rd_val = status;
        default: rd_val = '0;
      endcase
    end
  end

  mem_io_bridge_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tx_push), .push_data(cpu_data), .pop(tx_pop),
    .head(tx_data), .full(tx_full), .empty(tx_empty)
  );

  mem_io_bridge_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_push), .push_data(rx_data), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Access tracking, read-data capture and sticky error flags (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_prev <= '0;
      sel      <= 1'b0;
      io_rdata <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      acc_prev <= acc_cur;
      sel      <= hit;
      if (start) io_rdata <= rd_val;
      ovf <= ovf_set | (ovf & ~(st_wr & cpu_data[4]));
      udf <= udf_set | (udf & ~(st_wr & cpu_data[5]));
    end
  end

  assign cpu_in = sel ? io_rdata : mem_out;
endmodule
